// File: rtl/ldpc_vpu_core.sv
// Variable-node processing unit: sums intrinsic + 4 check messages, registers extrinsic and total LLRs.
// LDPC_VPU_SAT_EN defined: symmetric saturation to +/-MAX; undefined: two's-complement wraparound.
module ldpc_vpu_core #(
  parameter int COL_WEIGHT = 4,
  parameter int LLR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [LLR_WIDTH-1:0] llr_intri,
  input  logic [LLR_WIDTH-1:0] llr_in_0,
  input  logic [LLR_WIDTH-1:0] llr_in_1,
  input  logic [LLR_WIDTH-1:0] llr_in_2,
  input  logic [LLR_WIDTH-1:0] llr_in_3,
  output logic [LLR_WIDTH-1:0] llr_out_0,
  output logic [LLR_WIDTH-1:0] llr_out_1,
  output logic [LLR_WIDTH-1:0] llr_out_2,
  output logic [LLR_WIDTH-1:0] llr_out_3,
  output logic [LLR_WIDTH-1:0] llr_all
);

  generate
    if (COL_WEIGHT != 4) begin : g_bad_weight
      $error("ldpc_vpu_core supports COL_WEIGHT == 4 only");
    end
  endgenerate

`ifdef LDPC_VPU_SAT_EN
  // Three guard bits hold the sum of five LLR_WIDTH operands without overflow.
  localparam int SW = LLR_WIDTH + 3;
`else
  // Wraparound keeps only the low bits, which modular arithmetic at LLR_WIDTH already yields exactly.
  localparam int SW = LLR_WIDTH;
`endif
  localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (LLR_WIDTH - 1)) - 1);

  function automatic logic [LLR_WIDTH-1:0] clip(input logic signed [SW-1:0] x);
`ifdef LDPC_VPU_SAT_EN
    if (x > MAX_V) begin
      return MAX_V[LLR_WIDTH-1:0];
    end else if (x < -MAX_V) begin
      return LLR_WIDTH'(-MAX_V);
    end else begin
      return x[LLR_WIDTH-1:0];
    end
`else
    return x[LLR_WIDTH-1:0];
`endif
  endfunction

  logic signed [SW-1:0]  intri_ext;
  logic signed [SW-1:0]  in_ext [COL_WEIGHT];
  logic signed [SW-1:0]  sum;
  logic [LLR_WIDTH-1:0]  llr_all_d, llr_all_q;
  logic [LLR_WIDTH-1:0]  llr_out_d [COL_WEIGHT];
  logic [LLR_WIDTH-1:0]  llr_out_q [COL_WEIGHT];

  assign intri_ext = SW'(signed'(llr_intri));
  assign in_ext[0] = SW'(signed'(llr_in_0));
  assign in_ext[1] = SW'(signed'(llr_in_1));
  assign in_ext[2] = SW'(signed'(llr_in_2));
  assign in_ext[3] = SW'(signed'(llr_in_3));

  always_comb begin
    sum = intri_ext;
    for (int i = 0; i < COL_WEIGHT; i++) begin
      sum = sum + in_ext[i];
    end
    llr_all_d = llr_all_q;
    for (int i = 0; i < COL_WEIGHT; i++) begin
      llr_out_d[i] = llr_out_q[i];
    end
    // Extrinsic terms subtract from the unclipped sum so saturation never leaks between edges.
    if (en) begin
      llr_all_d = clip(sum);
      for (int i = 0; i < COL_WEIGHT; i++) begin
        llr_out_d[i] = clip(sum - in_ext[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      llr_all_q <= '0;
    end else begin
      llr_all_q <= llr_all_d;
    end
  end

  generate
    for (genvar gi = 0; gi < COL_WEIGHT; gi++) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          llr_out_q[gi] <= '0;
        end else begin
          llr_out_q[gi] <= llr_out_d[gi];
        end
      end
    end
  endgenerate

  assign llr_out_0 = llr_out_q[0];
  assign llr_out_1 = llr_out_q[1];
  assign llr_out_2 = llr_out_q[2];
  assign llr_out_3 = llr_out_q[3];
  assign llr_all   = llr_all_q;

endmodule

// File: tb/tb_ldpc_vpu_core.sv
// Self-checking bench for ldpc_vpu_core: directed steps plus random vectors against an integer model.
module tb_ldpc_vpu_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] intri = 8'h00;
  logic [7:0] in_v [4] = '{default: 8'h00};
  logic [7:0] out_0, out_1, out_2, out_3, all_o;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_all = 8'h00;
  logic [7:0] exp_out [4] = '{default: 8'h00};

  ldpc_vpu_core #(.COL_WEIGHT(4), .LLR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .llr_intri(intri),
    .llr_in_0(in_v[0]), .llr_in_1(in_v[1]), .llr_in_2(in_v[2]), .llr_in_3(in_v[3]),
    .llr_out_0(out_0), .llr_out_1(out_1), .llr_out_2(out_2), .llr_out_3(out_3),
    .llr_all(all_o)
  );

  always #5 clk = ~clk;

  // Reference clip on plain integers.
  function automatic logic [7:0] clipm(input int x);
`ifdef LDPC_VPU_SAT_EN
    if (x > 127) return 8'h7F;
    if (x < -127) return 8'h81;
    return x[7:0];
`else
    return x[7:0];
`endif
  endfunction

  function automatic int sv(input logic [7:0] b);
    return int'($signed(b));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".all"},  all_o, exp_all);
    chk({tag, ".out0"}, out_0, exp_out[0]);
    chk({tag, ".out1"}, out_1, exp_out[1]);
    chk({tag, ".out2"}, out_2, exp_out[2]);
    chk({tag, ".out3"}, out_3, exp_out[3]);
  endtask

  // Advance one edge, updating the model from what the DUT sees at that edge, then compare.
  task automatic cycle(input string tag);
    int s;
    if (rst) begin
      exp_all = 8'h00;
      for (int i = 0; i < 4; i++) exp_out[i] = 8'h00;
    end else if (en) begin
      s = sv(intri) + sv(in_v[0]) + sv(in_v[1]) + sv(in_v[2]) + sv(in_v[3]);
      exp_all = clipm(s);
      for (int i = 0; i < 4; i++) exp_out[i] = clipm(s - sv(in_v[i]));
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_vec(input logic [7:0] a, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    intri = a; in_v[0] = b0; in_v[1] = b1; in_v[2] = b2; in_v[3] = b3;
  endtask

  task automatic set_rand();
    set_vec(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    // Reset with random inputs and enable high.
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_rand();
      cycle("reset");
    end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand();
      cycle("post_reset_hold");
    end

    // Nominal vector, also pinned to hand-derived constants.
    en = 1'b1;
    set_vec(8'h22, 8'h28, 8'h45, 8'hA3, 8'h93);
    cycle("nominal");
    chk("nominal.all_const", all_o, 8'hC5);
    chk("nominal.out0_const", out_0, 8'h9D);
`ifdef LDPC_VPU_SAT_EN
    chk("nominal.out1_const", out_1, 8'h81);
`else
    chk("nominal.out1_const", out_1, 8'h80);
`endif
    chk("nominal.out2_const", out_2, 8'h22);
    chk("nominal.out3_const", out_3, 8'h32);

    set_vec(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    cycle("pos_sat");
    set_vec(8'h81, 8'h81, 8'h81, 8'h81, 8'h81);
    cycle("neg_sat");
    set_vec(8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    cycle("min_inputs");

    // Enable hold: reload nominal, then change inputs with en low.
    set_vec(8'h22, 8'h28, 8'h45, 8'hA3, 8'h93);
    cycle("reload_nominal");
    en = 1'b0;
    set_vec(8'h34, 8'hB2, 8'h41, 8'hA3, 8'h93);
    for (int i = 0; i < 10; i++) cycle("hold");
    set_vec('x, 'x, 'x, 'x, 'x);
    cycle("hold_x");
    set_vec(8'h34, 8'hB2, 8'h41, 8'hA3, 8'h93);
    en = 1'b1;
    cycle("hold_release");
    chk("hold_release.all_const", all_o, clipm(-163));

    // Back-to-back alternation, then reset mid-stream.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) set_vec(8'h22, 8'h28, 8'h45, 8'hA3, 8'h93);
      else            set_vec(8'h34, 8'hB2, 8'h41, 8'hA3, 8'h93);
      cycle("b2b");
    end
    rst = 1'b1;
    cycle("b2b_reset");
    rst = 1'b0;
    en = 1'b0;
    cycle("b2b_reset_idle");
    en = 1'b1;

    // Random traffic with random enable and occasional reset.
    for (int i = 0; i < 300; i++) begin
      set_rand();
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 40) == 0);
      cycle("random");
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
